// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: NOP word, PC increment, fetch FSM encoding
// and the beq opcode that the hazard unit also decodes.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [5:0]  OPC_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic is_beq(input logic [31:0] instr);
    return instr[31:26] == OPC_BEQ;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks an acked instruction while IF/ID is frozen.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // Clear wins over load so a redirect in the same cycle discards the word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      instr <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc4   <= load_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request handshake and the IF/ID register.
// Define FETCH_PERF_EN to add the saturating stall/flush performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        holdPC,
  input  logic        holdIF_ID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        fetch_stall
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  saved_target;
  logic [31:0]  pc_next_seq;
  logic [31:0]  target_aligned;
  logic         fire;
  logic         redirect;
  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc4;
  logic         skid_valid;

  // DRAIN keeps the killed request up so the handshake completes cleanly
  assign imem_req       = (state == DRAIN) || ((state == FETCH) && !holdPC);
  assign imem_addr      = pc;
  assign fire           = imem_req && imem_ack;
  assign fetch_stall    = imem_req && !imem_ack;
  assign redirect       = branch_taken && (state != BOOT);
  assign pc_next_seq    = pc + PC_INC;
  assign target_aligned = branch_target & ~32'h3;

  assign skid_load  = (state == FETCH) && fire && holdIF_ID && !redirect;
  assign skid_clear = redirect || ((state == HELD) && !holdIF_ID);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc4   (pc_next_seq),
    .instr      (skid_instr),
    .pc4        (skid_pc4),
    .valid      (skid_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC & ~32'h3;
      saved_target <= '0;
      IF_ID_Instr  <= NOP_INSTR;
      IF_ID_PC4    <= '0;
      IF_ID_Valid  <= 1'b0;
    end else if (redirect) begin
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
      if (fetch_stall) begin
        saved_target <= target_aligned;
        state        <= DRAIN;
      end else begin
        pc    <= target_aligned;
        state <= FETCH;
      end
    end else begin
      unique case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (fire) begin
            pc <= pc_next_seq;
            if (holdIF_ID) begin
              state <= HELD;
            end else begin
              IF_ID_Instr <= imem_rdata;
              IF_ID_PC4   <= pc_next_seq;
              IF_ID_Valid <= 1'b1;
            end
          end else if (!holdIF_ID) begin
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_PC4   <= '0;
            IF_ID_Valid <= 1'b0;
          end
        end
        HELD: begin
          if (!holdIF_ID) begin
            IF_ID_Instr <= skid_instr;
            IF_ID_PC4   <= skid_pc4;
            IF_ID_Valid <= skid_valid;
            state       <= FETCH;
          end
        end
        DRAIN: begin
          if (!holdIF_ID) begin
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_PC4   <= '0;
            IF_ID_Valid <= 1'b0;
          end
          if (imem_ack) begin
            pc    <= saved_target;
            state <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((fetch_stall || holdPC || holdIF_ID) && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a wait-state memory model and an
// IF/ID scoreboard. Define FETCH_PERF_EN to also exercise the perf counters.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic        holdPC;
  logic        holdIF_ID;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic        fetch_stall;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  sb_entry_t   sb[$];
  int          num_checks = 0;
  int          num_fails  = 0;
  int          mem_wait   = 0;
  int          wait_cnt   = 0;
  logic        cyc_req;
  logic        cyc_ack;
  logic        cyc_stall;
  logic [31:0] cyc_addr;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .reset         (reset),
    .holdPC        (holdPC),
    .holdIF_ID     (holdIF_ID),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PC4     (IF_ID_PC4),
    .IF_ID_Valid   (IF_ID_Valid),
`ifdef FETCH_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .fetch_stall   (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC3C3_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectFetch(input logic [31:0] addr);
    sb.push_back('{instr: mem_word(addr), pc4: addr + 32'd4});
  endtask

  // One clock cycle: drive controls, answer the memory request, then score IF/ID
  task automatic applyStimulus(input logic hold_pc, input logic hold_ifid,
                               input logic br, input logic [31:0] tgt);
    sb_entry_t exp_entry;
    @(negedge clk);
    holdPC        = hold_pc;
    holdIF_ID     = hold_ifid;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    imem_ack   = imem_req && (wait_cnt >= mem_wait);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    #1;
    cyc_req   = imem_req;
    cyc_ack   = imem_ack;
    cyc_addr  = imem_addr;
    cyc_stall = fetch_stall;
    @(posedge clk);
    #1;
    wait_cnt = (cyc_req && !cyc_ack) ? wait_cnt + 1 : 0;
    if (!hold_ifid && IF_ID_Valid) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_instr", IF_ID_Instr, 32'h0);
      end else begin
        exp_entry = sb.pop_front();
        checkOutput("sb_instr", IF_ID_Instr, exp_entry.instr);
        checkOutput("sb_pc4", IF_ID_PC4, exp_entry.pc4);
      end
    end
  endtask

  task automatic doReset();
    reset         = 1'b1;
    holdPC        = 1'b0;
    holdIF_ID     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    mem_wait      = 0;
    wait_cnt      = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_instr", IF_ID_Instr, 32'h0);
    checkOutput("rst_pc4", IF_ID_PC4, 32'h0);
    checkOutput("rst_valid", {31'h0, IF_ID_Valid}, 32'h0);
    checkOutput("rst_stall", {31'h0, fetch_stall}, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("boot_req", {31'h0, imem_req}, 32'h0);
  endtask

  initial begin
    $display("[TB] fetch_stage test starting");
    doReset();

    // Zero-wait streaming from RESET_PC
    expectFetch(32'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stream_addr0", cyc_addr, 32'h100);
    checkOutput("stream_req0", {31'h0, cyc_req}, 32'h1);
    checkOutput("stream_pc4_first", IF_ID_PC4, 32'h104);
    for (int i = 1; i < 4; i++) begin
      expectFetch(32'h100 + 32'(4 * i));
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("stream_addr", cyc_addr, 32'h100 + 32'(4 * i));
    end

    // Park an acked word while IF/ID is frozen, then release it
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("park_addr", cyc_addr, 32'h110);
    checkOutput("park_ifid_frozen", IF_ID_Instr, mem_word(32'h10C));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("held_req", {31'h0, cyc_req}, 32'h0);
      checkOutput("held_ifid", IF_ID_Instr, mem_word(32'h10C));
    end
    expectFetch(32'h110);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("unpark_req", {31'h0, cyc_req}, 32'h0);
    checkOutput("unpark_instr", IF_ID_Instr, mem_word(32'h110));
    expectFetch(32'h114);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after_park_addr", cyc_addr, 32'h114);

    // Redirect while IF/ID is valid
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
    checkOutput("flush_valid", {31'h0, IF_ID_Valid}, 32'h0);
    checkOutput("flush_instr", IF_ID_Instr, 32'h0);
    expectFetch(32'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("target_addr", cyc_addr, 32'h200);

    // Three wait states, redirect in the first wait cycle drains the old request
    mem_wait = 3;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ws_stall", {31'h0, cyc_stall}, 32'h1);
    checkOutput("ws_addr0", cyc_addr, 32'h204);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
    checkOutput("drain_addr1", cyc_addr, 32'h204);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drain_addr2", cyc_addr, 32'h204);
    checkOutput("drain_req2", {31'h0, cyc_req}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drain_addr3", cyc_addr, 32'h204);
    checkOutput("drain_ack3", {31'h0, cyc_ack}, 32'h1);
    checkOutput("drain_discard", {31'h0, IF_ID_Valid}, 32'h0);
    mem_wait = 0;
    expectFetch(32'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drain_target_addr", cyc_addr, 32'h200);

    // holdPC alone inserts a bubble and keeps the PC
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("bubble_req", {31'h0, cyc_req}, 32'h0);
    checkOutput("bubble_stall", {31'h0, cyc_stall}, 32'h0);
    checkOutput("bubble_valid", {31'h0, IF_ID_Valid}, 32'h0);
    checkOutput("bubble_instr", IF_ID_Instr, 32'h0);
    expectFetch(32'h204);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("bubble_pc_kept", cyc_addr, 32'h204);

    // PC wraps past the top of the address space; low target bits are dropped
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    expectFetch(32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr_top", cyc_addr, 32'hFFFF_FFFC);
    expectFetch(32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr_zero", cyc_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h303);
    expectFetch(32'h300);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("aligned_addr", cyc_addr, 32'h300);

    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

`ifdef FETCH_PERF_EN
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h400);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h500);
    checkOutput("perf_stall_cnt", perf_stall_cnt, 32'd5);
    checkOutput("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the program counter, drives the instruction-memory request handshake, and holds the IF/ID pipeline register. It sits directly upstream of the hazard detection unit. It consumes that unit's `holdPC` and `holdIF_ID` stall controls and the branch redirect from the branch-resolution stage. It produces `IF_ID_Instr`, which the hazard unit and the decode stage consume.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `holdPC`  in  1  freeze PC; no new fetch is issued.
- `holdIF_ID`  in  1  freeze the IF/ID register contents.
- `branch_taken`  in  1  redirect request; single-cycle pulse.
- `branch_target`  in  32  redirect address; sampled when `branch_taken`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and not acked.
- `imem_ack`  in  1  `imem_rdata` valid; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  fetched instruction.
- `IF_ID_Instr`  out  32  instruction to decode.
- `IF_ID_PC4`  out  32  PC+4 of that instruction.
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction.
- `fetch_stall`  out  1  request outstanding without ack.

## Operation
- States: BOOT, FETCH, HELD, DRAIN.
- **BOOT** (one cycle after reset release)
  - `imem_req`=0.
  - Next state: FETCH.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=PC, unless `holdPC`=1.
  - On `imem_ack` with `holdIF_ID`=0: IF/ID loads {`imem_rdata`, PC+4, valid=1}; PC<=PC+4; state stays FETCH.
  - On `imem_ack` with `holdIF_ID`=1: data goes to the skid buffer; PC<=PC+4; next state HELD.
  - No ack: `fetch_stall`=1.
- **HELD**
  - `imem_req`=0.
  - When `holdIF_ID`=0: IF/ID loads from the skid buffer; next state FETCH.
- **DRAIN** (entered when a redirect hits an un-acked request)
  - `imem_req` and `imem_addr` stay unchanged until ack.
  - On ack: data is discarded; PC<=saved target; next state FETCH.
- **Redirect** (`branch_taken`=1, any state except BOOT)
  - IF/ID <= {32'h0, 32'h0, valid=0}.
  - Skid buffer is cleared.
  - If no request is outstanding, or the ack arrives this cycle: PC<=`branch_target`, next state FETCH.
  - Otherwise: target is saved, next state DRAIN.
- **Priority:** `reset` > `branch_taken` > hold signals > normal flow.
- **`holdPC`=1, `holdIF_ID`=0:** IF/ID loads a bubble (instr 0, valid 0); PC is unchanged.
- **`holdIF_ID`=1:** IF/ID is unchanged regardless of `holdPC`.
- **PC arithmetic:** 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0; bits [1:0] are ignored and forced to 0 on `imem_addr`.

## Timing
- Reset values: PC=`RESET_PC`, state=BOOT, `imem_req`=0, `IF_ID_Instr`=0, `IF_ID_PC4`=0, `IF_ID_Valid`=0, `fetch_stall`=0, skid buffer empty.
- First request goes out in the cycle after reset deasserts.
- Throughput is one instruction per cycle with zero-wait memory.
  - Fetch latency is request to IF/ID update at the edge of the ack cycle.
- Redirect: the first target-path instruction reaches IF/ID no earlier than 1 cycle after the `branch_taken` edge, plus the memory wait states.
  - DRAIN adds the remaining wait cycles of the killed request.
- Reset asserted mid-request: state is abandoned immediately; no handshake completion is required.

## Configuration
- `FETCH_PERF_EN` defined adds two outputs:
  - `perf_stall_cnt` (32-bit): counts cycles with `fetch_stall`=1 or a hold active.
  - `perf_flush_cnt` (32-bit): counts redirects.
  - Both counters saturate at all-ones and reset to 0.
- `FETCH_PERF_EN` undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Shared package:
  - `NOP_INSTR` (32'h0) and PC increment constant (4).
  - Fetch-state encoding: BOOT, FETCH, HELD, DRAIN.
  - `beq` opcode 6'b000100, shared with the hazard unit.
- Sub-module `fetch_skid_buf`: one-entry buffer {instr, pc4} with load/clear/valid.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory, no holds -> `imem_addr` sequence 0x100, 0x104, 0x108 on consecutive cycles; `IF_ID_PC4`=0x104 one edge after the first ack.
- `holdPC`=`holdIF_ID`=1 for 2 cycles coinciding with an ack -> instruction is parked in HELD; `IF_ID_Instr` is unchanged for 2 cycles, then shows the parked word; no address is skipped.
- `branch_taken` with target 0x200 while IF/ID is valid -> next edge `IF_ID_Valid`=0 and `IF_ID_Instr`=0; next `imem_addr`=0x200.
- 3-wait-state memory, `branch_taken` in wait cycle 1 -> `imem_addr` is held until ack; the acked data never appears in IF/ID; the next request is 0x200.
- `holdPC`=1, `holdIF_ID`=0 -> IF/ID bubble (valid 0), PC unchanged; PC=32'hFFFF_FFFC fetch -> next `imem_addr`=0.
- With `FETCH_PERF_EN`, run 5 stall cycles and 2 redirects -> `perf_stall_cnt`=5, `perf_flush_cnt`=2.
